uart_frame_rx: RTL and testbench

Fabric-side receiver that consumes the serial line driven by the MSS UART_0_TXD and turns it into validated command frames for downstream fabric logic. It deserialises 8N1 bytes, hunts for a sync byte, captures a length-prefixed payload, and checks an XOR checksum. Good frames are released from a single frame buffer as a valid/ready byte stream with a LAST marker. Bad frames are dropped and reported through one-cycle status pulses.

---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 98 +++++++++
 rtl/uart_frame_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants, state encodings and sizing helpers for the UART frame receiver.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } parser_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Width able to hold every value 0..max_payload (LEN and payload indices).
  function automatic int idx_width(input int max_payload);
    return $clog2(max_payload + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: 2-FF synchroniser, mid-bit sampling, byte strobe and
// framing-error pulse, both registered and one cycle wide.
module uart_rx_byte
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       strobe_o,
  output logic       framing_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             strobe_q, strobe_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;

  assign rx_s          = sync_q[1];
  assign data_o        = shift_q;
  assign strobe_o      = strobe_q;
  assign framing_err_o = ferr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_ONE;
    bit_d    = bit_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) strobe_d = 1'b1;
          else      ferr_d   = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rxd_i};
      prev_q   <= rx_s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver: hunts for SYNC, captures a LEN-prefixed payload, checks the XOR
// checksum and releases good frames from a single buffer as a byte stream.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int MAX_PAYLOAD  = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] FRAME_DATA,
  output logic       FRAME_VALID,
  input  logic       FRAME_READY,
  output logic       FRAME_LAST,
  output logic       BUSY,
  output logic       CSUM_ERR,
  output logic       LEN_ERR,
  output logic       FRAMING_ERR,
  output logic       TIMEOUT,
  output logic       OVERRUN
);

  localparam int IDX_W    = idx_width(MAX_PAYLOAD);
  localparam int AW       = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_LIMIT - 1);
  localparam logic [7:0]       MAX_LEN = 8'(MAX_PAYLOAD);

  logic [7:0]       rx_data;
  logic             rx_strobe;
  logic             rx_ferr;

  parser_state_e    state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       xor_q, xor_d;
  logic             drop_q, drop_d;
  logic             full_q, full_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [IDX_W-1:0] out_len_q, out_len_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             csum_err_q, csum_err_d;
  logic             len_err_q, len_err_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       buf_q [MAX_PAYLOAD];
  logic             buf_we;
  logic             last_c;
  logic             final_hs;
  logic             to_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_i         (CLK),
    .rst_i         (RESET),
    .rxd_i         (RXD),
    .data_o        (rx_data),
    .strobe_o      (rx_strobe),
    .framing_err_o (rx_ferr)
  );

  // Stream handshake: a byte moves when FRAME_VALID && FRAME_READY at a rising CLK;
  // while VALID is high and READY low, DATA and LAST hold their values.
  assign last_c      = (rd_q == out_len_q - IDX_ONE);
  assign final_hs    = full_q && FRAME_READY && last_c;
  assign FRAME_VALID = full_q;
  assign FRAME_DATA  = full_q ? buf_q[rd_q[AW-1:0]] : 8'h00;
  assign FRAME_LAST  = full_q && last_c;
  assign BUSY        = (state_q != ST_HUNT) || full_q;
  assign CSUM_ERR    = csum_err_q;
  assign LEN_ERR     = len_err_q;
  assign FRAMING_ERR = rx_ferr;
  assign TIMEOUT     = timeout_q;
  assign OVERRUN     = overrun_q;

  assign to_hit = (state_q != ST_HUNT) && !rx_strobe && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    drop_d     = drop_q;
    full_d     = full_q;
    rd_d       = rd_q;
    out_len_d  = out_len_q;
    to_cnt_d   = to_cnt_q;
    csum_err_d = 1'b0;
    len_err_d  = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;
    buf_we     = 1'b0;

    // The strobe cycle itself counts as the first cycle of the inter-byte gap.
    if (rx_strobe)              to_cnt_d = TO_ONE;
    else if (state_q == ST_HUNT) to_cnt_d = '0;
    else                        to_cnt_d = to_cnt_q + TO_ONE;

    if (full_q && FRAME_READY) begin
      if (last_c) full_d = 1'b0;
      else        rd_d   = rd_q + IDX_ONE;
    end

    if (rx_ferr) begin
      state_d = ST_HUNT;
    end else if (to_hit) begin
      timeout_d = 1'b1;
      state_d   = ST_HUNT;
    end else if (rx_strobe) begin
      case (state_q)
        ST_HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_LEN;
            // A buffer emptied by this very cycle's last handshake is free.
            drop_d  = full_q && !final_hs;
          end
        end
        ST_LEN: begin
          if (rx_data == 8'h00 || rx_data > MAX_LEN) begin
            len_err_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            len_d   = rx_data[IDX_W-1:0];
            xor_d   = rx_data;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          buf_we = !drop_q;
          xor_d  = xor_q ^ rx_data;
          if (idx_q == len_q - IDX_ONE) state_d = ST_CSUM;
          else                          idx_d   = idx_q + IDX_ONE;
        end
        ST_CSUM: begin
          state_d = ST_HUNT;
          if (rx_data != xor_q) begin
            csum_err_d = 1'b1;
          end else if (drop_q) begin
            overrun_d = 1'b1;
          end else begin
            full_d    = 1'b1;
            rd_d      = '0;
            out_len_d = len_q;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_HUNT;
      len_q      <= '0;
      idx_q      <= '0;
      xor_q      <= 8'h00;
      drop_q     <= 1'b0;
      full_q     <= 1'b0;
      rd_q       <= '0;
      out_len_q  <= '0;
      to_cnt_q   <= '0;
      csum_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      drop_q     <= drop_d;
      full_q     <= full_d;
      rd_q       <= rd_d;
      out_len_q  <= out_len_d;
      to_cnt_q   <= to_cnt_d;
      csum_err_q <= csum_err_d;
      len_err_q  <= len_err_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (buf_we) buf_q[idx_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: serial driver, frame-level reference model feeding
// byte and event queues, and a monitor that pops and compares DUT activity.
module tb_uart_frame_rx;

  localparam int CPB   = 4;
  localparam int MAXP  = 16;
  localparam int TOB   = 20;
  localparam int EV_CSUM = 1, EV_LEN = 2, EV_FR = 3, EV_TO = 4, EV_OVR = 5;

  typedef logic [7:0] byte_q_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       frame_ready;
  logic [7:0] frame_data;
  logic       frame_valid, frame_last, busy;
  logic       csum_err, len_err, framing_err, timeout, overrun;

  logic [8:0]  exp_q [$];
  int          evt_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc = 0;
  int unsigned last_start_cyc = 0;
  int unsigned valid_rise_cyc = 0;
  int unsigned timeout_cyc = 0;
  int unsigned first_hs_cyc = 0;
  int unsigned last_hs_cyc = 0;
  int          hs_count = 0;
  bit          rand_ready = 1'b0;
  logic        ready_fixed = 1'b1;

  uart_frame_rx #(
    .CLKS_PER_BIT (CPB),
    .MAX_PAYLOAD  (MAXP),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .RXD         (rxd),
    .FRAME_DATA  (frame_data),
    .FRAME_VALID (frame_valid),
    .FRAME_READY (frame_ready),
    .FRAME_LAST  (frame_last),
    .BUSY        (busy),
    .CSUM_ERR    (csum_err),
    .LEN_ERR     (len_err),
    .FRAMING_ERR (framing_err),
    .TIMEOUT     (timeout),
    .OVERRUN     (overrun)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_ready = 1'b1;
    forever begin
      @(negedge clk);
      frame_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic byte_q_t make_frame(input int len, input bit corrupt);
    byte_q_t    fr;
    logic [7:0] x;
    logic [7:0] b;
    fr.push_back(8'hA5);
    fr.push_back(8'(len));
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      fr.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    fr.push_back(x);
    return fr;
  endfunction

  // Outcome of one complete frame sent from the hunting state.
  task automatic expect_frame(input byte_q_t fr, input bit draining);
    int         len;
    logic [7:0] x;
    len = int'(fr[1]);
    if (len == 0 || len > MAXP) begin
      evt_q.push_back(EV_LEN);
    end else begin
      x = fr[1];
      for (int i = 0; i < len; i++) x = x ^ fr[2+i];
      if (fr[2+len] != x)  evt_q.push_back(EV_CSUM);
      else if (draining)   evt_q.push_back(EV_OVR);
      else for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), fr[2+i]});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_raw(input logic [7:0] b, input logic stop_bit);
    last_start_cyc = cyc;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_frame(input byte_q_t fr, input bit gaps);
    foreach (fr[i]) begin
      send_raw(fr[i], 1'b1);
      if (gaps) repeat (CPB * $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while ((busy || frame_valid || exp_q.size() != 0 || evt_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      $display("FAIL %s: wait for idle expired, busy=%0b valid=%0b bytes_left=%0d events_left=%0d",
               name, busy, frame_valid, exp_q.size(), evt_q.size());
    end
  endtask

  task automatic wait_events(input string name);
    int n;
    n = 0;
    while (evt_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      $display("FAIL %s: expected event never seen, events_left=%0d", name, evt_q.size());
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic pop_evt(input int code, input string name);
    if (evt_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got %s pulse, expected no event", name);
    end else begin
      check({"event_", name}, 32'(code), 32'(evt_q.pop_front()));
    end
  endtask

  initial begin
    logic       pv, pr, pl;
    logic [7:0] pd;
    logic [8:0] e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", 32'(frame_valid), 32'd1);
          check("hold_data", 32'(frame_data), 32'(pd));
          check("hold_last", 32'(frame_last), 32'(pl));
        end
        if (frame_valid && !pv) valid_rise_cyc = cyc;
        if (frame_valid && frame_ready) begin
          if (hs_count == 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          hs_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got data=%02h last=%0b, expected no output",
                     frame_data, frame_last);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", 32'({frame_last, frame_data}), 32'(e));
          end
        end
        if (csum_err)    pop_evt(EV_CSUM, "csum_err");
        if (len_err)     pop_evt(EV_LEN, "len_err");
        if (framing_err) pop_evt(EV_FR, "framing_err");
        if (timeout) begin
          timeout_cyc = cyc;
          pop_evt(EV_TO, "timeout");
        end
        if (overrun)     pop_evt(EV_OVR, "overrun");
        pv = frame_valid; pr = frame_ready; pd = frame_data; pl = frame_last;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    byte_q_t     fr, fr2;
    int unsigned csum_start, aa_start;
    int          n;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(frame_valid), 32'd0);
    check("reset_data", 32'(frame_data), 32'd0);
    check("reset_last", 32'(frame_last), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pulses", 32'({csum_err, len_err, framing_err, timeout, overrun}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed good frame, consumer always ready.
    fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    expect_frame(fr, 1'b0);
    hs_count = 0;
    for (int i = 0; i < 5; i++) send_raw(fr[i], 1'b1);
    send_raw(fr[5], 1'b1);
    csum_start = last_start_cyc;
    wait_idle("good_frame");
    check("valid_latency", valid_rise_cyc, csum_start + 42);
    check("stream_count", 32'(hs_count), 32'd3);
    check("stream_back_to_back", last_hs_cyc - first_hs_cyc, 32'd2);

    // Bad checksum, then a good frame.
    fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    expect_frame(fr, 1'b0);
    send_frame(fr, 1'b0);
    wait_idle("bad_csum");
    fr = make_frame(5, 1'b0);
    expect_frame(fr, 1'b0);
    send_frame(fr, 1'b0);
    wait_idle("good_after_bad");

    // Illegal lengths 0 and 17.
    fr = '{8'hA5, 8'h00};
    expect_frame(fr, 1'b0);
    send_frame(fr, 1'b0);
    wait_idle("len_zero");
    fr = '{8'hA5, 8'h11};
    expect_frame(fr, 1'b0);
    send_frame(fr, 1'b0);
    wait_idle("len_17");

    // Maximum length, A5 bytes inside the payload treated as data.
    fr = '{8'hA5, 8'h10, 8'hA5, 8'h01, 8'hA5, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
           8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hA5, 8'h00};
    fr[18] = 8'h10;
    for (int i = 2; i < 18; i++) fr[18] = fr[18] ^ fr[i];
    expect_frame(fr, 1'b0);
    send_frame(fr, 1'b1);
    wait_idle("max_len");

    // Overrun: consumer stalled while a second good frame arrives.
    ready_fixed = 1'b0;
    repeat (2) @(negedge clk);
    fr = make_frame(4, 1'b0);
    expect_frame(fr, 1'b0);
    send_frame(fr, 1'b0);
    n = 0;
    while (!frame_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("stalled_valid", 32'(frame_valid), 32'd1);
    fr2 = make_frame(3, 1'b0);
    expect_frame(fr2, 1'b1);
    send_frame(fr2, 1'b0);
    wait_events("overrun");
    check("stalled_bytes_left", 32'(exp_q.size()), 32'd4);
    ready_fixed = 1'b1;
    wait_idle("overrun_drain");

    // Inter-byte timeout after A5 02 AA.
    evt_q.push_back(EV_TO);
    send_raw(8'hA5, 1'b1);
    send_raw(8'h02, 1'b1);
    send_raw(8'hAA, 1'b1);
    aa_start = last_start_cyc;
    wait_events("timeout");
    check("timeout_cycle", timeout_cyc, aa_start + 41 + TOB * CPB);
    repeat (2) @(negedge clk);
    check("timeout_busy", 32'(busy), 32'd0);

    // Framing error mid-frame.
    evt_q.push_back(EV_FR);
    send_raw(8'hA5, 1'b1);
    send_raw(8'h02, 1'b1);
    send_raw(8'h3C, 1'b0);
    wait_events("framing");
    repeat (2) @(negedge clk);
    check("framing_busy", 32'(busy), 32'd0);

    // One-cycle low glitch on an idle line is rejected.
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd0);
    fr = make_frame(2, 1'b0);
    expect_frame(fr, 1'b0);
    send_frame(fr, 1'b0);
    wait_idle("after_glitch");

    // Randomized frames with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      fr = make_frame($urandom_range(1, MAXP), ($urandom_range(0, 3) == 0));
      expect_frame(fr, 1'b0);
      send_frame(fr, 1'b1);
      wait_idle("random_frame");
    end
    rand_ready = 1'b0;
    ready_fixed = 1'b1;

    // Reset while a committed frame waits to drain.
    ready_fixed = 1'b0;
    repeat (2) @(negedge clk);
    fr = make_frame(6, 1'b0);
    expect_frame(fr, 1'b0);
    send_frame(fr, 1'b0);
    n = 0;
    while (!frame_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_valid", 32'(frame_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("reset_drain_valid", 32'(frame_valid), 32'd0);
    check("reset_drain_busy", 32'(busy), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    ready_fixed = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_valid", 32'(frame_valid), 32'd0);

    check("bytes_left", 32'(exp_q.size()), 32'd0);
    check("events_left", 32'(evt_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
